pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline control unit: merges per-stage stall requests, self-timed multi-cycle

---
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard control. Merges per-stage stall requests, self-timed
//   multi-cycle stalls (mul/div) and exception flushes into per-stage stall
//   controls, a global flush and a PC redirect.
//
// Ports
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous reset, active-low
//   stallreq  in   STAGES  level stall request, bit k raised by stage k
//   mc_start  in   1       pulse: start a self-timed stall of mc_len cycles
//   mc_len    in   LEN_W   self-timed stall length, sampled with mc_start
//   excp_req  in   1       exception pulse: flush pipeline, redirect PC
//   excp_pc   in   AW      redirect target, sampled with excp_req
//   stall     out  STAGES  stall[k]=1 holds stage k register
//   flush     out  1       clear all pipeline registers (registered)
//   new_pc    out  AW      redirect PC, valid while flush=1, held afterwards
//   busy      out  1       1 while the controller is not in RUN
//   wdog_err  out  1       sticky stall watchdog flag
//
// Optional feature macro: STALL_WDOG_EN
//   When defined, a counter tracks consecutive cycles with stall[0]=1 and
//   raises wdog_err once WDOG_LIM cycles are reached. When undefined the
//   watchdog is not built and wdog_err is tied low.

module pipe_hazard_ctrl #(
  parameter int STAGES    = 6,
  parameter int MC_STAGE  = 3,
  parameter int LEN_W     = 6,
  parameter int FLUSH_CYC = 1,
  parameter int AW        = 32,
  parameter int WDOG_LIM  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              mc_start,
  input  logic [LEN_W-1:0]  mc_len,
  input  logic              excp_req,
  input  logic [AW-1:0]     excp_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [AW-1:0]     new_pc,
  output logic              busy,
  output logic              wdog_err
);

  typedef enum logic [1:0] {RUN, MC, FLUSH} state_t;

  localparam logic [LEN_W-1:0] FLUSH_LOAD = LEN_W'(FLUSH_CYC - 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic [AW-1:0]     new_pc_q, new_pc_d;
  logic [STAGES-1:0] mc_mask;
  logic [STAGES-1:0] req_vec;
  logic [STAGES-1:0] stall_c;

  // The multi-cycle owner stage stalls already in the mc_start cycle, so a
  // stall of mc_len cycles begins in the same cycle as the request.
  always_comb begin
    mc_mask = '0;
    if ((state_q == MC) ||
        ((state_q == RUN) && mc_start && (mc_len != '0)))
      mc_mask[MC_STAGE] = 1'b1;
  end

  assign req_vec = stallreq | mc_mask;

  // A request at stage j holds every upstream stage 0..j. Stall is
  // suppressed while flushing since every register is being cleared anyway.
  always_comb begin
    stall_c = '0;
    for (int k = 0; k < STAGES; k++)
      stall_c[k] = |(req_vec >> k);
    if (state_q == FLUSH)
      stall_c = '0;
  end

  // Next-state logic. An exception wins over everything else in every state;
  // in FLUSH it restarts the flush window with the newest redirect target.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    new_pc_d = new_pc_q;
    case (state_q)
      RUN: begin
        if (excp_req) begin
          state_d  = FLUSH;
          new_pc_d = excp_pc;
          cnt_d    = FLUSH_LOAD;
          flush_d  = 1'b1;
        end else if (mc_start && (mc_len > LEN_W'(1))) begin
          state_d = MC;
          cnt_d   = mc_len - LEN_W'(1);
        end
      end
      MC: begin
        if (excp_req) begin
          state_d  = FLUSH;
          new_pc_d = excp_pc;
          cnt_d    = FLUSH_LOAD;
          flush_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1))
            state_d = RUN;
        end
      end
      FLUSH: begin
        if (excp_req) begin
          new_pc_d = excp_pc;
          cnt_d    = FLUSH_LOAD;
          flush_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        flush_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign stall  = stall_c;
  assign flush  = flush_q;
  assign new_pc = new_pc_q;
  assign busy   = (state_q != RUN);

`ifdef STALL_WDOG_EN
  localparam int WCNT_W = $clog2(WDOG_LIM) + 1;

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wdog_q, wdog_d;

  // Count consecutive stalled cycles at the PC stage; the counter parks at
  // the limit so the flag cannot be lost by wrap-around.
  always_comb begin
    wcnt_d = wcnt_q;
    wdog_d = wdog_q;
    if (stall_c[0]) begin
      if (wcnt_q == WCNT_W'(WDOG_LIM - 1))
        wdog_d = 1'b1;
      else
        wcnt_d = wcnt_q + WCNT_W'(1);
    end else begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Instance u_dut uses the default
//   configuration (FLUSH_CYC=1) with WDOG_LIM=16; instance u_dut3 uses
//   FLUSH_CYC=3 for the repeated-exception flush window.

module tb_pipe_hazard_ctrl;

  localparam int STAGES = 6;
  localparam int LEN_W  = 6;
  localparam int AW     = 32;

`ifdef STALL_WDOG_EN
  localparam logic WDOG_ON = 1'b1;
`else
  localparam logic WDOG_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [STAGES-1:0] stallreq;
  logic              mc_start;
  logic [LEN_W-1:0]  mc_len;
  logic              excp_req;
  logic [AW-1:0]     excp_pc;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [AW-1:0]     new_pc;
  logic              busy;
  logic              wdog_err;

  logic [STAGES-1:0] d3_stallreq;
  logic              d3_mc_start;
  logic [LEN_W-1:0]  d3_mc_len;
  logic              d3_excp_req;
  logic [AW-1:0]     d3_excp_pc;
  logic [STAGES-1:0] d3_stall;
  logic              d3_flush;
  logic [AW-1:0]     d3_new_pc;
  logic              d3_busy;
  logic              d3_wdog_err;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.WDOG_LIM(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .stallreq (stallreq),
    .mc_start (mc_start),
    .mc_len   (mc_len),
    .excp_req (excp_req),
    .excp_pc  (excp_pc),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .busy     (busy),
    .wdog_err (wdog_err)
  );

  pipe_hazard_ctrl #(.FLUSH_CYC(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .stallreq (d3_stallreq),
    .mc_start (d3_mc_start),
    .mc_len   (d3_mc_len),
    .excp_req (d3_excp_req),
    .excp_pc  (d3_excp_pc),
    .stall    (d3_stall),
    .flush    (d3_flush),
    .new_pc   (d3_new_pc),
    .busy     (d3_busy),
    .wdog_err (d3_wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b0;
    stallreq    = '0;
    mc_start    = 1'b0;
    mc_len      = '0;
    excp_req    = 1'b0;
    excp_pc     = '0;
    d3_stallreq = '0;
    d3_mc_start = 1'b0;
    d3_mc_len   = '0;
    d3_excp_req = 1'b0;
    d3_excp_pc  = '0;

    // Reset values
    #2;
    check_output("rst_stall",  32'(stall),    32'h0);
    check_output("rst_flush",  32'(flush),    32'h0);
    check_output("rst_busy",   32'(busy),     32'h0);
    check_output("rst_newpc",  new_pc,        32'h0);
    check_output("rst_wdog",   32'(wdog_err), 32'h0);
    check_output("rst_flush3", 32'(d3_flush), 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // Test 1: single request stalls all upstream stages combinationally
    tick();
    stallreq = 6'b000100;
    #1;
    check_output("t1_stall", 32'(stall), 32'h07);
    check_output("t1_flush", 32'(flush), 32'h0);
    check_output("t1_busy",  32'(busy),  32'h0);

    // Test 2: highest request dominates, release clears
    tick();
    stallreq = 6'b001010;
    #1;
    check_output("t2_stall", 32'(stall), 32'h0f);
    tick();
    stallreq = '0;
    #1;
    check_output("t2_release", 32'(stall), 32'h00);

    // Test 3: self-timed stall of 5 cycles
    tick();
    mc_start = 1'b1;
    mc_len   = 6'd5;
    #1;
    check_output("t3_stall_t0", 32'(stall), 32'h0f);
    check_output("t3_busy_t0",  32'(busy),  32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      mc_start = 1'b0;
      #1;
      check_output($sformatf("t3_stall_t%0d", i), 32'(stall), 32'h0f);
      check_output($sformatf("t3_busy_t%0d", i),  32'(busy),  32'h1);
    end
    tick();
    #1;
    check_output("t3_stall_t5", 32'(stall), 32'h00);
    check_output("t3_busy_t5",  32'(busy),  32'h0);

    // mc_len=1: one stall cycle without leaving RUN; mc_len=0 ignored
    tick();
    mc_start = 1'b1;
    mc_len   = 6'd1;
    #1;
    check_output("len1_stall", 32'(stall), 32'h0f);
    tick();
    mc_start = 1'b0;
    #1;
    check_output("len1_after_stall", 32'(stall), 32'h00);
    check_output("len1_after_busy",  32'(busy),  32'h0);
    mc_start = 1'b1;
    mc_len   = 6'd0;
    #1;
    check_output("len0_stall", 32'(stall), 32'h00);
    tick();
    mc_start = 1'b0;
    #1;
    check_output("len0_busy", 32'(busy), 32'h0);

    // Test 4: exception aborts a multi-cycle stall
    tick();
    mc_start = 1'b1;
    mc_len   = 6'd5;
    tick();
    mc_start = 1'b0;
    tick();
    excp_req = 1'b1;
    excp_pc  = 32'h20;
    #1;
    check_output("t4_stall_excp", 32'(stall), 32'h0f);
    check_output("t4_flush_excp", 32'(flush), 32'h0);
    tick();
    excp_req = 1'b0;
    excp_pc  = '0;
    stallreq = 6'b000100;
    #1;
    check_output("t4_flush",  32'(flush), 32'h1);
    check_output("t4_newpc",  new_pc,     32'h20);
    check_output("t4_stall0", 32'(stall), 32'h00);
    check_output("t4_busy",   32'(busy),  32'h1);
    tick();
    #1;
    check_output("t4_flush_end", 32'(flush), 32'h0);
    check_output("t4_busy_end",  32'(busy),  32'h0);
    check_output("t4_stall_run", 32'(stall), 32'h07);
    check_output("t4_newpc_hold", new_pc,    32'h20);
    stallreq = '0;

    // Test 5: repeated exception during a 3-cycle flush window
    tick();
    d3_excp_req = 1'b1;
    d3_excp_pc  = 32'h10;
    tick();
    d3_excp_req = 1'b0;
    #1;
    check_output("t5_flush_f1", 32'(d3_flush), 32'h1);
    check_output("t5_newpc_f1", d3_new_pc,     32'h10);
    tick();
    d3_excp_req = 1'b1;
    d3_excp_pc  = 32'h40;
    #1;
    check_output("t5_flush_f2", 32'(d3_flush), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      d3_excp_req = 1'b0;
      #1;
      check_output($sformatf("t5_flush_g%0d", i), 32'(d3_flush), 32'h1);
      check_output($sformatf("t5_newpc_g%0d", i), d3_new_pc,     32'h40);
    end
    tick();
    #1;
    check_output("t5_flush_end", 32'(d3_flush), 32'h0);
    check_output("t5_busy_end",  32'(d3_busy),  32'h0);
    check_output("t5_newpc_hold", d3_new_pc,    32'h40);

    // Test 6: asynchronous reset mid-MC
    tick();
    mc_start = 1'b1;
    mc_len   = 6'd10;
    tick();
    mc_start = 1'b0;
    #1;
    check_output("t6_busy_pre", 32'(busy), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_output("t6_stall_rst", 32'(stall), 32'h00);
    check_output("t6_flush_rst", 32'(flush), 32'h0);
    check_output("t6_busy_rst",  32'(busy),  32'h0);
    check_output("t6_newpc_rst", new_pc,     32'h0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    check_output("t6_busy_after", 32'(busy), 32'h0);

    // Watchdog: 16 consecutive stalled cycles at the PC stage
    tick();
    stallreq = 6'b000100;
    for (int i = 0; i < 15; i++)
      tick();
    #1;
    check_output("wdog_before", 32'(wdog_err), 32'h0);
    tick();
    #1;
    check_output("wdog_set", 32'(wdog_err), 32'(WDOG_ON));
    stallreq = '0;
    tick();
    tick();
    #1;
    check_output("wdog_sticky", 32'(wdog_err), 32'(WDOG_ON));
    check_output("wdog_stall_released", 32'(stall), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
